// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the accumulator processor control unit.
// Opcode map, ALU/bus select encodings and the sequencer state enum.
package control_sequencer_pkg;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_NAND = 2'd3;

  localparam logic [1:0] BUS_OPND = 2'd0;
  localparam logic [1:0] BUS_RAM  = 2'd1;
  localparam logic [1:0] BUS_IN   = 2'd2;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_JUMP  = 2'd2,
    ST_MEM   = 2'd3
  } state_t;

endpackage

// File: rtl/control_sequencer_decode.sv
// cs_decode: pure combinational opcode decode.
// Ports: instr (opcode) -> instruction class flags (two_byte, is_jump,
// is_mem, is_store), the enables the op asserts when it executes
// (acc_en, flags_en, out_en) and its ALU/bus selects. The sequencer
// decides in which cycle these are actually driven out.
module cs_decode
  import control_sequencer_pkg::*;
(
  input  logic [3:0] instr,
  output logic       two_byte,
  output logic       is_jump,
  output logic       is_mem,
  output logic       is_store,
  output logic       acc_en,
  output logic       flags_en,
  output logic       out_en,
  output logic [1:0] alu_op,
  output logic [1:0] bus_sel
);

  always_comb begin
    two_byte = 1'b0;
    is_jump  = 1'b0;
    is_mem   = 1'b0;
    is_store = 1'b0;
    acc_en   = 1'b0;
    flags_en = 1'b0;
    out_en   = 1'b0;
    alu_op   = ALU_PASS;
    bus_sel  = BUS_OPND;
    case (instr)
      OP_LIT:   acc_en = 1'b1;
      OP_IN:    begin acc_en = 1'b1; bus_sel = BUS_IN; end
      OP_CMPI:  begin flags_en = 1'b1; alu_op = ALU_SUB; end
      OP_ADDI:  begin acc_en = 1'b1; flags_en = 1'b1; alu_op = ALU_ADD; end
      OP_NANDI: begin acc_en = 1'b1; flags_en = 1'b1; alu_op = ALU_NAND; end
      OP_OUT:   out_en = 1'b1;
      OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: begin
        two_byte = 1'b1;
        is_jump  = 1'b1;
      end
      OP_CMPM: begin
        two_byte = 1'b1; is_mem = 1'b1; flags_en = 1'b1;
        alu_op = ALU_SUB; bus_sel = BUS_RAM;
      end
      OP_LD: begin
        two_byte = 1'b1; is_mem = 1'b1; acc_en = 1'b1;
        alu_op = ALU_PASS; bus_sel = BUS_RAM;
      end
      OP_ST: begin
        two_byte = 1'b1; is_mem = 1'b1; is_store = 1'b1;
      end
      OP_ADDM: begin
        two_byte = 1'b1; is_mem = 1'b1; acc_en = 1'b1; flags_en = 1'b1;
        alu_op = ALU_ADD; bus_sel = BUS_RAM;
      end
      OP_NANDM: begin
        two_byte = 1'b1; is_mem = 1'b1; acc_en = 1'b1; flags_en = 1'b1;
        alu_op = ALU_NAND; bus_sel = BUS_RAM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute sequencer for the 4-bit accumulator CPU.
// Owns the PC and a FETCH/EXEC/JUMP/MEM state machine; drives all datapath
// load enables, ALU/bus selects and RAM strobes combinationally from the
// current state and the fetched opcode (no extra output latency).
// Ports: clk, reset (sync, active high), run, instr/operand (fetch reg),
// prog_byte (ROM data at pc), c_flag/z_flag, ram_ready -> pc, addr,
// en_fetch/en_acc/en_flags/en_out, alu_op, bus_sel, ram_re/ram_we,
// phase, busy.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [3:0]      instr,
  input  logic [3:0]      operand,
  input  logic [7:0]      prog_byte,
  input  logic            c_flag,
  input  logic            z_flag,
  input  logic            ram_ready,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] addr,
  output logic            en_fetch,
  output logic            en_acc,
  output logic            en_flags,
  output logic            en_out,
  output logic [1:0]      alu_op,
  output logic [1:0]      bus_sel,
  output logic            ram_re,
  output logic            ram_we,
  output logic            phase,
  output logic            busy
);

  state_t     state;
  logic [7:0] addr_lo;
  logic [11:0] target;
  logic       taken;

  logic       d_two_byte, d_is_jump, d_is_mem, d_is_store;
  logic       d_acc_en, d_flags_en, d_out_en;
  logic [1:0] d_alu_op, d_bus_sel;

  cs_decode u_decode (
    .instr    (instr),
    .two_byte (d_two_byte),
    .is_jump  (d_is_jump),
    .is_mem   (d_is_mem),
    .is_store (d_is_store),
    .acc_en   (d_acc_en),
    .flags_en (d_flags_en),
    .out_en   (d_out_en),
    .alu_op   (d_alu_op),
    .bus_sel  (d_bus_sel)
  );

  // Operand nibble supplies the page, second byte the offset.
  assign target = {operand, addr_lo};
  assign addr   = PC_W'(target);

  always_comb begin
    case (instr)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = c_flag;
      OP_JNC:  taken = ~c_flag;
      OP_JZ:   taken = z_flag;
      OP_JNZ:  taken = ~z_flag;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      addr_lo <= '0;
    end else begin
      case (state)
        ST_FETCH: if (run) begin
          pc    <= pc + PC_W'(1);
          state <= ST_EXEC;
        end
        ST_EXEC: if (d_two_byte) begin
          // Second byte is ROM data at the already-incremented pc.
          addr_lo <= prog_byte;
          pc      <= pc + PC_W'(1);
          state   <= d_is_jump ? ST_JUMP : ST_MEM;
        end else begin
          state <= ST_FETCH;
        end
        ST_JUMP: begin
          if (taken) pc <= PC_W'(target);
          state <= ST_FETCH;
        end
        ST_MEM: if (ram_ready) state <= ST_FETCH;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Strobes are forced low while reset is high so an aborted access never
  // commits anything in the reset cycle.
  always_comb begin
    en_fetch = 1'b0;
    en_acc   = 1'b0;
    en_flags = 1'b0;
    en_out   = 1'b0;
    alu_op   = ALU_PASS;
    bus_sel  = BUS_OPND;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: en_fetch = run;
        ST_EXEC: if (!d_two_byte) begin
          en_acc   = d_acc_en;
          en_flags = d_flags_en;
          en_out   = d_out_en;
          alu_op   = d_alu_op;
          bus_sel  = d_bus_sel;
        end
        ST_MEM: if (d_is_mem) begin
          alu_op   = d_alu_op;
          bus_sel  = d_bus_sel;
          ram_we   = d_is_store;
          ram_re   = ~d_is_store;
          en_acc   = ram_ready & d_acc_en;
          en_flags = ram_ready & d_flags_en;
        end
        default: ;
      endcase
    end
  end

  assign phase = (state != ST_FETCH);
  assign busy  = (state != ST_FETCH);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: random ROM image with a directed program overlay,
// random run/flags/ram_ready/reset, checked against an instruction-level
// reference model that walks each instruction's expected cycle sequence.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, c_flag, z_flag, ram_ready;
  logic [3:0]  instr, operand;
  logic [7:0]  prog_byte;
  logic [11:0] pc, addr;
  logic        en_fetch, en_acc, en_flags, en_out, ram_re, ram_we, phase, busy;
  logic [1:0]  alu_op, bus_sel;

  logic [7:0]  rom [4096];
  logic [7:0]  fetch_reg = 8'h00;
  int          checks = 0;
  int          failures = 0;
  int          mpc;
  bit          inject_rst = 1'b0;

  control_sequencer #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .operand(operand),
    .prog_byte(prog_byte), .c_flag(c_flag), .z_flag(z_flag),
    .ram_ready(ram_ready), .pc(pc), .addr(addr), .en_fetch(en_fetch),
    .en_acc(en_acc), .en_flags(en_flags), .en_out(en_out), .alu_op(alu_op),
    .bus_sel(bus_sel), .ram_re(ram_re), .ram_we(ram_we), .phase(phase),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment: asynchronous ROM and the fetch register.
  assign prog_byte        = rom[pc];
  assign {instr, operand} = fetch_reg;
  always @(posedge clk) if (en_fetch) fetch_reg <= prog_byte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {fetch, acc, flags, out, re, we}
  task automatic chk_strobes(input string tag, input logic [5:0] exp);
    chk(tag, 32'({en_fetch, en_acc, en_flags, en_out, ram_re, ram_we}), 32'(exp));
  endtask

  // Drives one cycle of random inputs at the falling edge. A reset cycle is
  // checked here and restarts the model at the reset PC.
  task automatic begin_cycle(output bit rst);
    @(negedge clk);
    rst       = inject_rst && ($urandom_range(0, 299) == 0);
    reset     = rst;
    run       = ($urandom_range(0, 3) != 0);
    c_flag    = 1'($urandom_range(0, 1));
    z_flag    = 1'($urandom_range(0, 1));
    ram_ready = ($urandom_range(0, 2) == 0);
    #1;
    if (rst) begin
      chk_strobes("reset_strobes", 6'b0);
      mpc = 0;
    end
  endtask

  task automatic do_instr();
    bit          r;
    logic [7:0]  op, b;
    logic [11:0] tgt;
    logic        acc, fl, o, tk, st;
    logic [1:0]  aop, bsel;
    int          w;

    begin_cycle(r);
    if (r) return;
    chk("fetch_pc", 32'(pc), 32'(mpc));
    chk("fetch_busy", 32'({phase, busy}), 32'(0));
    chk_strobes("fetch_strobes", {run, 5'b0});
    if (!run) return;
    op  = rom[mpc[11:0]];
    mpc = (mpc + 1) % 4096;

    begin_cycle(r);
    if (r) return;
    chk("exec_pc", 32'(pc), 32'(mpc));
    chk("exec_busy", 32'({phase, busy}), 32'(3));
    acc = 0; fl = 0; o = 0; aop = 0; bsel = 0;
    case (op[7:4])
      4'h2, 4'h4, 4'h5, 4'hA, 4'hD, 4'hE: begin
        case (op[7:4])
          4'h4: begin acc = 1; aop = 0; bsel = 0; end
          4'h5: begin acc = 1; aop = 0; bsel = 2; end
          4'h2: begin fl = 1;  aop = 2; bsel = 0; end
          4'hA: begin acc = 1; fl = 1; aop = 1; bsel = 0; end
          4'hE: begin acc = 1; fl = 1; aop = 3; bsel = 0; end
          default: o = 1;
        endcase
        chk_strobes("exec1_strobes", {1'b0, acc, fl, o, 2'b00});
        if (!o) begin
          chk("exec1_alu", 32'(alu_op), 32'(aop));
          chk("exec1_bus", 32'(bus_sel), 32'(bsel));
        end
      end
      default: begin
        chk_strobes("exec2_strobes", 6'b0);
        b   = rom[mpc[11:0]];
        mpc = (mpc + 1) % 4096;
        tgt = {op[3:0], b};
        if (op[7:4] inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC}) begin
          begin_cycle(r);
          if (r) return;
          chk("jump_pc", 32'(pc), 32'(mpc));
          chk("jump_busy", 32'(busy), 32'(1));
          chk_strobes("jump_strobes", 6'b0);
          case (op[7:4])
            4'h0:    tk = c_flag;
            4'h1:    tk = !c_flag;
            4'h8:    tk = z_flag;
            4'h9:    tk = !z_flag;
            default: tk = 1'b1;
          endcase
          if (tk) mpc = int'(tgt);
        end else begin
          st = (op[7:4] == 4'h7);
          case (op[7:4])
            4'h3:    begin fl = 1; aop = 2; end
            4'h6:    begin acc = 1; aop = 0; end
            4'hB:    begin acc = 1; fl = 1; aop = 1; end
            4'hF:    begin acc = 1; fl = 1; aop = 3; end
            default: ;
          endcase
          w = 0;
          forever begin
            begin_cycle(r);
            if (r) return;
            if (w >= 5 && !ram_ready) begin ram_ready = 1'b1; #1; end
            chk("mem_pc", 32'(pc), 32'(mpc));
            chk("mem_addr", 32'(addr), 32'(tgt));
            chk("mem_busy", 32'(busy), 32'(1));
            chk_strobes("mem_strobes",
                        {1'b0, ram_ready & acc, ram_ready & fl, 1'b0, !st, st});
            if (!st) chk("mem_bus", 32'(bus_sel), 32'(1));
            if (ram_ready && (acc || fl)) chk("mem_alu", 32'(alu_op), 32'(aop));
            if (ram_ready) break;
            w++;
          end
        end
      end
    endcase
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; c_flag = 1'b0; z_flag = 1'b0; ram_ready = 1'b1;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    // LIT 7; JMP 0x345; JZ 0x2A0; JMP 0xFFF; LD at 0xFFF whose second byte
    // comes from address 0 after wrap (LD 0x247).
    rom[12'h000] = 8'h47; rom[12'h001] = 8'hC3; rom[12'h002] = 8'h45;
    rom[12'h345] = 8'h82; rom[12'h346] = 8'hA0;
    rom[12'h347] = 8'hCF; rom[12'h348] = 8'hFF;
    rom[12'hFFF] = 8'h62;

    // Reset held with run and ram_ready high: nothing may strobe.
    @(negedge clk); #1;
    chk_strobes("init_reset_strobes0", 6'b0);
    @(negedge clk); #1;
    chk_strobes("init_reset_strobes1", 6'b0);
    chk("init_reset_pc", 32'(pc), 32'(0));
    chk("init_reset_busy", 32'({phase, busy}), 32'(0));
    mpc = 0;

    for (int n = 0; n < 3000; n++) begin
      if (n == 400) inject_rst = 1'b1;
      do_instr();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
